arcade_input_mapper: RTL and testbench

//  Parametrised keyboard/joystick-to-cabinet-button mapper for arcade cores.

---
 rtl/arcade_input_mapper_if.sv | 27 ++
 rtl/arcade_input_mapper.sv | 127 ++++++++++++
 tb/tb_arcade_input_mapper.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_mapper_if.sv
`default_nettype none
// ============================================================================
//  Module   : arcade_input_mapper_if
//  Purpose  : PS/2 key-event bus from user_io into the cabinet button mapper.
//  Revision : 1.0
// ============================================================================
interface arcade_input_mapper_if;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;

    modport master (
        output key_strobe,
        output key_pressed,
        output key_extended,
        output key_code
    );

    modport slave (
        input  key_strobe,
        input  key_pressed,
        input  key_extended,
        input  key_code
    );
endinterface
`default_nettype wire

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : arcade_input_mapper
//  Purpose  : Maps PS/2 keys and two joysticks onto cabinet buttons, with coin
//             pulse shaping and per-button autofire. All outputs registered.
//  Revision : 1.0
// ============================================================================
module arcade_input_mapper #(
    parameter int                     NUM_BTN       = 10,
    parameter logic [9*NUM_BTN-1:0]   KEYMAP        = {9'h006, 9'h005, 9'h076, 9'h014, 9'h011,
                                                       9'h029, 9'h174, 9'h16B, 9'h172, 9'h175},
    parameter int                     COIN_IDX      = 7,
    parameter int                     COIN_PULSE    = 500000,
    parameter logic [NUM_BTN-1:0]     AUTOFIRE_MASK = 10'h070,
    parameter int                     AUTOFIRE_DIV  = 100000
) (
    input  wire logic                 clk_sys,
    input  wire logic                 reset,
    arcade_input_mapper_if.slave      key,
    input  wire logic [NUM_BTN-1:0]   joystick_0,
    input  wire logic [NUM_BTN-1:0]   joystick_1,
    input  wire logic                 autofire_en,
    output logic      [NUM_BTN-1:0]   btn_out
);

    localparam int c_CW = $clog2(COIN_PULSE + 1);
    localparam int c_AW = $clog2(AUTOFIRE_DIV + 1);

    logic [NUM_BTN-1:0] r_key_state;
    logic               r_af_en_prev;
    logic [NUM_BTN-1:0] w_raw;

    // Every table entry is compared, so duplicated codes drive all of their buttons.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_key_state <= '0;
        end else if (key.key_strobe) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if ((KEYMAP[9*i +: 8] != 8'h00) &&
                    (KEYMAP[9*i +: 9] == {key.key_extended, key.key_code})) begin
                    r_key_state[i] <= key.key_pressed;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) r_af_en_prev <= 1'b0;
        else       r_af_en_prev <= autofire_en;
    end

    assign w_raw = r_key_state | joystick_0 | joystick_1;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic r_btn;
        assign btn_out[i] = r_btn;

        if (i == COIN_IDX) begin : g_coin
            logic            r_prev;
            logic [c_CW-1:0] r_cnt;
            logic            w_rise;

            assign w_rise = w_raw[i] & ~r_prev;

            // Counter holds the remaining pulse length; zero means idle and output low.
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_prev <= 1'b0;
                    r_cnt  <= '0;
                    r_btn  <= 1'b0;
                end else begin
                    r_prev <= w_raw[i];
                    if (r_cnt == '0) begin
                        if (w_rise) begin
                            r_cnt <= c_CW'(COIN_PULSE);
                            r_btn <= 1'b1;
                        end else begin
                            r_btn <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CW'(1);
                        r_btn <= (r_cnt > c_CW'(1));
                    end
                end
            end
        end else if (AUTOFIRE_MASK[i]) begin : g_af
            logic            r_prev;
            logic [c_AW-1:0] r_phase;
            logic            w_start;

            // Enabling autofire while the button is held restarts the burst like a fresh press.
            assign w_start = w_raw[i] & (~r_prev | ~r_af_en_prev);

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_prev  <= 1'b0;
                    r_phase <= '0;
                    r_btn   <= 1'b0;
                end else begin
                    r_prev <= w_raw[i];
                    if (!autofire_en) begin
                        r_phase <= '0;
                        r_btn   <= w_raw[i];
                    end else if (!w_raw[i]) begin
                        r_phase <= '0;
                        r_btn   <= 1'b0;
                    end else if (w_start) begin
                        r_phase <= '0;
                        r_btn   <= 1'b1;
                    end else if (r_phase == c_AW'(AUTOFIRE_DIV - 1)) begin
                        r_phase <= '0;
                        r_btn   <= ~r_btn;
                    end else begin
                        r_phase <= r_phase + c_AW'(1);
                    end
                end
            end
        end else begin : g_plain
            always_ff @(posedge clk_sys) begin
                if (reset) r_btn <= 1'b0;
                else       r_btn <= w_raw[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arcade_input_mapper
//  Purpose  : Directed self-checking bench for arcade_input_mapper.
//  Revision : 1.0
// ============================================================================
module tb_arcade_input_mapper;

    localparam int c_NB = 10;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [c_NB-1:0]   joystick_0;
    logic [c_NB-1:0]   joystick_1;
    logic              autofire_en;
    logic [c_NB-1:0]   btn_out;

    int checks   = 0;
    int failures = 0;

    arcade_input_mapper_if kbus();

    // Entry 6 duplicates entry 4 (9'h029); entry 9 is an empty 9'h000 slot.
    arcade_input_mapper #(
        .NUM_BTN       (c_NB),
        .KEYMAP        ({9'h000, 9'h005, 9'h076, 9'h029, 9'h011,
                         9'h029, 9'h174, 9'h16B, 9'h172, 9'h175}),
        .COIN_IDX      (7),
        .COIN_PULSE    (4),
        .AUTOFIRE_MASK (10'h070),
        .AUTOFIRE_DIV  (3)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .key         (kbus.slave),
        .joystick_0  (joystick_0),
        .joystick_1  (joystick_1),
        .autofire_en (autofire_en),
        .btn_out     (btn_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One-cycle strobe; the key latch updates on the edge consumed here.
    task automatic key_event(input logic ext, input logic [7:0] code, input logic pressed);
        kbus.key_strobe   = 1'b1;
        kbus.key_extended = ext;
        kbus.key_code     = code;
        kbus.key_pressed  = pressed;
        tick();
        kbus.key_strobe   = 1'b0;
    endtask

    logic [11:0] af_pat;

    initial begin
        reset             = 1'b1;
        joystick_0        = '0;
        joystick_1        = '0;
        autofire_en       = 1'b0;
        kbus.key_strobe   = 1'b0;
        kbus.key_pressed  = 1'b0;
        kbus.key_extended = 1'b0;
        kbus.key_code     = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        check("reset_btn", 32'(btn_out), 32'h0);

        // Extended key E0 75 -> button 0 with two-cycle latency.
        key_event(1'b1, 8'h75, 1'b1);
        check("key_up_lat1", 32'(btn_out[0]), 32'h0);
        tick();
        check("key_up_lat2", 32'(btn_out), 32'h001);
        key_event(1'b1, 8'h75, 1'b0);
        check("key_up_brk1", 32'(btn_out[0]), 32'h1);
        tick();
        check("key_up_brk2", 32'(btn_out), 32'h0);
        key_event(1'b0, 8'h75, 1'b1);
        tick();
        tick();
        check("key_noext_75", 32'(btn_out), 32'h0);

        // Joystick 1 bit 5 for three cycles, plain (autofire off).
        joystick_1[5] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) joystick_1[5] = 1'b0;
            tick();
            check($sformatf("joy1_b5_c%0d", c), 32'(btn_out), (c < 3) ? 32'h020 : 32'h0);
        end

        // Coin held 20 cycles via key 76: four-cycle pulse starting one cycle after latch.
        key_event(1'b0, 8'h76, 1'b1);
        check("coin_k1", 32'(btn_out[7]), 32'h0);
        for (int k = 2; k <= 20; k++) begin
            tick();
            check($sformatf("coin_k%0d", k), 32'(btn_out[7]), (k <= 5) ? 32'h1 : 32'h0);
        end
        key_event(1'b0, 8'h76, 1'b0);
        tick();
        check("coin_rel", 32'(btn_out), 32'h0);

        // Re-press during the pulse is ignored; holding afterwards gives no new pulse.
        joystick_0[7] = 1'b1;
        tick();
        check("coin_rp1", 32'(btn_out[7]), 32'h1);
        joystick_0[7] = 1'b0;
        tick();
        check("coin_rp2", 32'(btn_out[7]), 32'h1);
        joystick_0[7] = 1'b1;
        tick();
        check("coin_rp3", 32'(btn_out[7]), 32'h1);
        tick();
        check("coin_rp4", 32'(btn_out[7]), 32'h1);
        tick();
        check("coin_rp5", 32'(btn_out[7]), 32'h0);
        tick();
        check("coin_rp6", 32'(btn_out[7]), 32'h0);
        joystick_0[7] = 1'b0;
        tick();

        // Autofire on button 4, half-period 3.
        autofire_en   = 1'b1;
        af_pat        = 12'b111000111000;
        joystick_0[4] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("af_k%0d", k), 32'(btn_out[4]), 32'(af_pat[11-k]));
        end
        joystick_0[4] = 1'b0;
        tick();
        check("af_release", 32'(btn_out), 32'h0);

        // Autofire enable rising while held restarts the burst; falling reverts to plain.
        autofire_en   = 1'b0;
        joystick_0[5] = 1'b1;
        tick();
        tick();
        check("af_plain_hold", 32'(btn_out[5]), 32'h1);
        autofire_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("af_en_rise_k%0d", k), 32'(btn_out[5]), (k < 3) ? 32'h1 : 32'h0);
        end
        autofire_en = 1'b0;
        tick();
        check("af_en_fall", 32'(btn_out[5]), 32'h1);
        joystick_0[5] = 1'b0;
        tick();
        check("af_plain_rel", 32'(btn_out), 32'h0);

        // Duplicate code 29 drives buttons 4 and 6 together; code 00 never matches.
        key_event(1'b0, 8'h29, 1'b1);
        tick();
        check("dup_make", 32'(btn_out), 32'h050);
        key_event(1'b0, 8'h29, 1'b0);
        tick();
        check("dup_break", 32'(btn_out), 32'h0);
        key_event(1'b0, 8'h00, 1'b1);
        tick();
        check("code00", 32'(btn_out), 32'h0);

        // Reset mid coin pulse with a key held, strobe in the same cycle as reset.
        key_event(1'b1, 8'h75, 1'b1);
        tick();
        joystick_0[7] = 1'b1;
        tick();
        check("pre_rst", 32'(btn_out), 32'h081);
        joystick_0[7] = 1'b0;
        tick();
        reset             = 1'b1;
        kbus.key_strobe   = 1'b1;
        kbus.key_extended = 1'b1;
        kbus.key_code     = 8'h72;
        kbus.key_pressed  = 1'b1;
        tick();
        kbus.key_strobe = 1'b0;
        check("rst_mid", 32'(btn_out), 32'h0);
        reset = 1'b0;
        tick();
        check("post_rst1", 32'(btn_out), 32'h0);
        tick();
        check("post_rst2", 32'(btn_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
